channel_frame_serializer: RTL and testbench

//  Parametrised N-channel frame serializer for the SFP TX path. Captures TUSER..TLAST framed streams

---
 rtl/channel_frame_serializer.sv | 213 +++++++++++++++++++++
 tb/tb_channel_frame_serializer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_frame_serializer.sv
// channel_frame_serializer
// Captures framed streams from CHANNEL_NUM sources into per-channel FIFOs and
// emits whole frames, one at a time and round-robin, onto a single write bus.
module channel_frame_serializer #(
    parameter int CHANNEL_NUM   = 8,
    parameter int DATA_WIDTH    = 64,
    parameter int FIFO_DEPTH    = 2048,
    parameter int MAX_FRAME_LEN = 256
) (
    input  logic                              TX_ACLK,
    input  logic                              TX_ARESET,
    input  logic [CHANNEL_NUM*DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [CHANNEL_NUM-1:0]            S_AXIS_TUSER,
    input  logic [CHANNEL_NUM-1:0]            S_AXIS_TLAST,
    input  logic [CHANNEL_NUM-1:0]            S_AXIS_TVALID,
    input  logic                              PLS_WAIT,
    output logic [DATA_WIDTH-1:0]             SERIALIZED_DATA,
    output logic                              WR_EN,
    output logic                              FRAME_LAST,
    output logic [$clog2(CHANNEL_NUM)-1:0]    CHANNEL_ID,
    output logic                              BUSY,
    output logic [CHANNEL_NUM-1:0]            OVERFLOW
);
    localparam int CW  = $clog2(CHANNEL_NUM);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int LW  = $clog2(MAX_FRAME_LEN + 1);

    typedef enum logic [1:0] {CAP_IDLE, CAP_STORE, CAP_DROP} cap_state_t;
    typedef enum logic {ARB_IDLE, ARB_SEND} arb_state_t;

    logic [CHANNEL_NUM*DATA_WIDTH-1:0] in_data;
    logic [CHANNEL_NUM-1:0]            in_user, in_last, in_valid;
    logic [CHANNEL_NUM-1:0]            has_frame;
    logic [DATA_WIDTH:0]               head_word [CHANNEL_NUM];
    logic [DATA_WIDTH:0]               pop_word;
    arb_state_t                        state, state_next;
    logic [CW-1:0]                     grant, grant_next, rr, rr_next;
    logic [CW-1:0]                     sel_ch, idx;
    logic                              sel_found, pop, pop_last;

    // Register the raw input streams once before any capture decision.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge TX_ACLK or posedge TX_ARESET) begin
        if (TX_ARESET) begin
            in_data  <= '0;
            in_user  <= '0;
            in_last  <= '0;
            in_valid <= '0;
        end else begin
            in_data  <= S_AXIS_TDATA;
            in_user  <= S_AXIS_TUSER;
            in_last  <= S_AXIS_TLAST;
            in_valid <= S_AXIS_TVALID;
        end
    end

    for (genvar k = 0; k < CHANNEL_NUM; k++) begin : g_ch
        cap_state_t            cap_state, cap_next;
        logic [LW-1:0]         word_cnt, cnt_next;
        logic [PW-1:0]         wr_ptr, rd_ptr, free_words;
        logic [FCW-1:0]        frame_cnt;
        logic                  wr_req, wr_last, ovf_set, last_wr_q, ovf_q, pop_here;
        logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
        logic [DATA_WIDTH-1:0] ch_data;

        assign ch_data      = in_data[k*DATA_WIDTH +: DATA_WIDTH];
        assign free_words   = PW'(FIFO_DEPTH) - (wr_ptr - rd_ptr);
        assign pop_here     = pop && (grant == CW'(k));
        assign head_word[k] = mem[rd_ptr[AW-1:0]];
        assign has_frame[k] = (frame_cnt != '0);
        assign OVERFLOW[k]  = ovf_q;

        // Frame capture: admission at frame start, truncation at MAX_FRAME_LEN.
        // NOTE: every output gets a default first so no path infers a latch.
        always_comb begin
            cap_next = cap_state;
            cnt_next = word_cnt;
            wr_req   = 1'b0;
            wr_last  = 1'b0;
            ovf_set  = 1'b0;
            if (in_valid[k]) begin
                unique case (cap_state)
                    CAP_IDLE: begin
                        if (in_user[k]) begin
                            if (free_words >= PW'(MAX_FRAME_LEN)) begin
                                wr_req   = 1'b1;
                                cnt_next = LW'(1);
                            end else begin
                                ovf_set  = 1'b1;
                                cap_next = in_last[k] ? CAP_IDLE : CAP_DROP;
                            end
                        end
                    end
                    CAP_STORE: begin
                        wr_req   = 1'b1;
                        cnt_next = word_cnt + LW'(1);
                    end
                    CAP_DROP: begin
                        if (in_last[k]) cap_next = CAP_IDLE;
                    end
                    default: cap_next = CAP_IDLE;
                endcase
                if (wr_req) begin
                    wr_last  = in_last[k] || (cnt_next == LW'(MAX_FRAME_LEN));
                    cap_next = !wr_last ? CAP_STORE : (in_last[k] ? CAP_IDLE : CAP_DROP);
                end
            end
        end

        // Capture state, FIFO pointers, completed-frame count and sticky drop flag.
        always_ff @(posedge TX_ACLK or posedge TX_ARESET) begin
            if (TX_ARESET) begin
                cap_state <= CAP_IDLE;
                word_cnt  <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                frame_cnt <= '0;
                last_wr_q <= 1'b0;
                ovf_q     <= 1'b0;
            end else begin
                cap_state <= cap_next;
                word_cnt  <= cnt_next;
                if (wr_req)   wr_ptr <= wr_ptr + PW'(1);
                if (pop_here) rd_ptr <= rd_ptr + PW'(1);
                // The count lags the stored last word by one cycle, which keeps
                // the TLAST-to-WR_EN latency at four cycles.
                last_wr_q <= wr_req && wr_last;
                frame_cnt <= frame_cnt + FCW'(last_wr_q) - FCW'(pop_here && pop_last);
                if (ovf_set) ovf_q <= 1'b1;
            end
        end

        // FIFO storage write port: {last_flag, data}.
        // NOTE: storage has no reset; the pointers alone define valid contents.
        always_ff @(posedge TX_ACLK) begin
            if (wr_req) mem[wr_ptr[AW-1:0]] <= {wr_last, ch_data};
        end
    end

    assign pop_word = head_word[grant];
    assign pop_last = pop_word[DATA_WIDTH];
    assign BUSY     = (state == ARB_SEND);

    // Round-robin search: first channel with a complete frame after rr.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        idx       = '0;
        for (int i = 1; i <= CHANNEL_NUM; i++) begin
            idx = CW'((int'(rr) + i) % CHANNEL_NUM);
            if (!sel_found && has_frame[idx]) begin
                sel_found = 1'b1;
                sel_ch    = idx;
            end
        end
    end

    // Arbiter state register.
    always_ff @(posedge TX_ACLK or posedge TX_ARESET) begin
        if (TX_ARESET) begin
            state <= ARB_IDLE;
            grant <= '0;
            rr    <= CW'(CHANNEL_NUM - 1);
        end else begin
            state <= state_next;
            grant <= grant_next;
            rr    <= rr_next;
        end
    end

    // Arbiter next state: grant in IDLE, pop one word per free cycle in SEND.
    always_comb begin
        state_next = state;
        grant_next = grant;
        rr_next    = rr;
        pop        = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (sel_found) begin
                    grant_next = sel_ch;
                    rr_next    = sel_ch;
                    state_next = ARB_SEND;
                end
            end
            ARB_SEND: begin
                if (!PLS_WAIT) begin
                    pop = 1'b1;
                    if (pop_last) state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Registered output stage: one WR_EN per popped word.
    always_ff @(posedge TX_ACLK or posedge TX_ARESET) begin
        if (TX_ARESET) begin
            WR_EN           <= 1'b0;
            FRAME_LAST      <= 1'b0;
            SERIALIZED_DATA <= '0;
            CHANNEL_ID      <= '0;
        end else begin
            WR_EN      <= pop;
            FRAME_LAST <= pop && pop_last;
            if (pop) begin
                SERIALIZED_DATA <= pop_word[DATA_WIDTH-1:0];
                CHANNEL_ID      <= grant;
            end
        end
    end
endmodule

// File: tb/tb_channel_frame_serializer.sv
// Directed bench for channel_frame_serializer with hand-computed expectations.
module tb_channel_frame_serializer;
    localparam int CN = 8;
    localparam int DW = 64;

    logic           TX_ACLK = 1'b0;
    logic           TX_ARESET;
    logic [CN*DW-1:0] s_tdata;
    logic [CN-1:0]  s_tuser, s_tlast, s_tvalid;
    logic           PLS_WAIT;
    logic [DW-1:0]  SERIALIZED_DATA;
    logic           WR_EN, FRAME_LAST, BUSY;
    logic [2:0]     CHANNEL_ID;
    logic [CN-1:0]  OVERFLOW;

    typedef struct {
        logic [2:0]    ch;
        logic          last;
        logic [DW-1:0] data;
        int            cyc;
    } rec_t;

    rec_t mon_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    channel_frame_serializer #(
        .CHANNEL_NUM(CN), .DATA_WIDTH(DW), .FIFO_DEPTH(2048), .MAX_FRAME_LEN(256)
    ) dut (
        .TX_ACLK(TX_ACLK),
        .TX_ARESET(TX_ARESET),
        .S_AXIS_TDATA(s_tdata),
        .S_AXIS_TUSER(s_tuser),
        .S_AXIS_TLAST(s_tlast),
        .S_AXIS_TVALID(s_tvalid),
        .PLS_WAIT(PLS_WAIT),
        .SERIALIZED_DATA(SERIALIZED_DATA),
        .WR_EN(WR_EN),
        .FRAME_LAST(FRAME_LAST),
        .CHANNEL_ID(CHANNEL_ID),
        .BUSY(BUSY),
        .OVERFLOW(OVERFLOW)
    );

    always #5 TX_ACLK = ~TX_ACLK;

    always @(posedge TX_ACLK) cyc <= cyc + 1;

    // Output log, sampled on the falling edge.
    always @(negedge TX_ACLK) begin
        if (WR_EN === 1'b1) mon_q.push_back('{CHANNEL_ID, FRAME_LAST, SERIALIZED_DATA, cyc});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge TX_ACLK);
        #1;
    endtask

    task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input int ch, input logic [63:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            s_tdata[ch*DW +: DW] = base + 64'(i);
            s_tvalid[ch] = 1'b1;
            s_tuser[ch]  = (i == 0);
            s_tlast[ch]  = (i == len - 1);
            tick();
        end
        s_tvalid[ch] = 1'b0;
        s_tuser[ch]  = 1'b0;
        s_tlast[ch]  = 1'b0;
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int k = 0;
        while (mon_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        expect_eq(tag, 64'(mon_q.size() >= n), 64'd1);
    endtask

    task automatic wait_wr_en(input string tag, input int budget);
        int k = 0;
        while (WR_EN !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        expect_eq(tag, 64'(WR_EN), 64'd1);
    endtask

    task automatic do_reset();
        TX_ARESET = 1'b1;
        tick();
        tick();
        TX_ARESET = 1'b0;
        tick();
    endtask

    initial begin
        int held, later, errs, lasts, dead, j;
        int lens[8] = '{256, 256, 256, 256, 256, 256, 256, 156};
        int chs[3]  = '{0, 1, 7};

        TX_ARESET = 1'b1;
        s_tdata   = '0;
        s_tuser   = '0;
        s_tlast   = '0;
        s_tvalid  = '0;
        PLS_WAIT  = 1'b0;
        tick();
        tick();

        // Reset state
        expect_eq("rst_wr_en", 64'(WR_EN), 64'd0);
        expect_eq("rst_frame_last", 64'(FRAME_LAST), 64'd0);
        expect_eq("rst_busy", 64'(BUSY), 64'd0);
        expect_eq("rst_overflow", 64'(OVERFLOW), 64'd0);
        expect_eq("rst_data", SERIALIZED_DATA, 64'd0);
        expect_eq("rst_channel_id", 64'(CHANNEL_ID), 64'd0);
        TX_ARESET = 1'b0;
        tick();

        // 1: ch2 three-word frame, first WR_EN four edges after TLAST sampled
        send_frame(2, 64'hA0, 3);
        tick();
        tick();
        tick();
        expect_eq("t1_no_early_wr", 64'(WR_EN), 64'd0);
        tick();
        expect_eq("t1_w0_en", 64'(WR_EN), 64'd1);
        expect_eq("t1_w0_data", SERIALIZED_DATA, 64'hA0);
        expect_eq("t1_w0_ch", 64'(CHANNEL_ID), 64'd2);
        expect_eq("t1_w0_last", 64'(FRAME_LAST), 64'd0);
        expect_eq("t1_busy", 64'(BUSY), 64'd1);
        tick();
        expect_eq("t1_w1_data", SERIALIZED_DATA, 64'hA1);
        expect_eq("t1_w1_en", 64'(WR_EN), 64'd1);
        tick();
        expect_eq("t1_w2_data", SERIALIZED_DATA, 64'hA2);
        expect_eq("t1_w2_last", 64'(FRAME_LAST), 64'd1);
        tick();
        expect_eq("t1_done_en", 64'(WR_EN), 64'd0);

        // 2: ch0, ch1, ch7 frames ready together after reset (rr = 7)
        do_reset();
        mon_q.delete();
        for (int i = 0; i < 2; i++) begin
            foreach (chs[c]) begin
                s_tdata[chs[c]*DW +: DW] = 64'h2000 + 64'(chs[c] * 16 + i);
                s_tvalid[chs[c]] = 1'b1;
                s_tuser[chs[c]]  = (i == 0);
                s_tlast[chs[c]]  = (i == 1);
            end
            tick();
        end
        s_tvalid = '0;
        s_tuser  = '0;
        s_tlast  = '0;
        wait_words("t2_count", 6, 50);
        if (mon_q.size() >= 6) begin
            expect_eq("t2_ch_0", 64'(mon_q[0].ch), 64'd0);
            expect_eq("t2_ch_2", 64'(mon_q[2].ch), 64'd1);
            expect_eq("t2_ch_4", 64'(mon_q[4].ch), 64'd7);
            expect_eq("t2_data_5", mon_q[5].data, 64'h2071);
            expect_eq("t2_last_1", 64'(mon_q[1].last), 64'd1);
            expect_eq("t2_in_frame_gap", 64'(mon_q[1].cyc - mon_q[0].cyc), 64'd1);
            expect_eq("t2_idle_gap_a", 64'(mon_q[2].cyc - mon_q[1].cyc), 64'd2);
            expect_eq("t2_idle_gap_b", 64'(mon_q[4].cyc - mon_q[3].cyc), 64'd2);
        end

        // 3: PLS_WAIT high for five cycles inside a 10-word ch1 frame
        mon_q.delete();
        send_frame(1, 64'h3000, 10);
        wait_wr_en("t3_start", 20);
        tick();
        tick();
        PLS_WAIT = 1'b1;
        held  = 0;
        later = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            held += int'(WR_EN);
            if (i > 0) later += int'(WR_EN);
        end
        expect_eq("t3_at_most_one", 64'(held <= 1), 64'd1);
        expect_eq("t3_none_further", 64'(later), 64'd0);
        expect_eq("t3_busy_hold", 64'(BUSY), 64'd1);
        PLS_WAIT = 1'b0;
        wait_words("t3_count", 10, 50);
        repeat (5) tick();
        expect_eq("t3_total", 64'(mon_q.size()), 64'd10);
        if (mon_q.size() >= 10) begin
            errs = 0;
            for (int i = 0; i < 10; i++) begin
                if (mon_q[i].data !== 64'h3000 + 64'(i)) errs++;
                if (mon_q[i].last !== (i == 9)) errs++;
            end
            expect_eq("t3_sequence", 64'(errs), 64'd0);
        end

        // 4: ch3 filled to 100 free words; next frame dropped, OVERFLOW[3] set
        mon_q.delete();
        PLS_WAIT = 1'b1;
        j = 0;
        foreach (lens[f]) begin
            send_frame(3, 64'h4_0000 + 64'(j), lens[f]);
            j += lens[f];
        end
        send_frame(3, 64'hDEAD_0000, 5);
        repeat (5) tick();
        expect_eq("t4_overflow", 64'(OVERFLOW), 64'h08);
        expect_eq("t4_quiet_while_wait", 64'(mon_q.size()), 64'd0);
        PLS_WAIT = 1'b0;
        wait_words("t4_count", 1948, 3000);
        repeat (20) tick();
        expect_eq("t4_total", 64'(mon_q.size()), 64'd1948);
        errs  = 0;
        lasts = 0;
        dead  = 0;
        foreach (mon_q[i]) begin
            if (mon_q[i].data !== 64'h4_0000 + 64'(i)) errs++;
            if (mon_q[i].data[31:16] === 16'hDEAD) dead++;
            if (mon_q[i].last === 1'b1) lasts++;
        end
        expect_eq("t4_order", 64'(errs), 64'd0);
        expect_eq("t4_dropped_absent", 64'(dead), 64'd0);
        expect_eq("t4_frame_lasts", 64'(lasts), 64'd8);

        // 5: ch4 300-word frame truncated to 256, following frame intact
        mon_q.delete();
        send_frame(4, 64'h5000, 300);
        send_frame(4, 64'h5800, 3);
        wait_words("t5_count", 259, 1000);
        repeat (10) tick();
        expect_eq("t5_total", 64'(mon_q.size()), 64'd259);
        if (mon_q.size() >= 259) begin
            lasts = 0;
            for (int i = 0; i < 256; i++) if (mon_q[i].last === 1'b1) lasts++;
            expect_eq("t5_one_last", 64'(lasts), 64'd1);
            expect_eq("t5_w255_last", 64'(mon_q[255].last), 64'd1);
            expect_eq("t5_w255_data", mon_q[255].data, 64'h50FF);
            expect_eq("t5_next_first", mon_q[256].data, 64'h5800);
            expect_eq("t5_next_last", 64'(mon_q[258].last), 64'd1);
            expect_eq("t5_next_ch", 64'(mon_q[258].ch), 64'd4);
        end

        // 6: reset during SEND of a ch5 frame, then a clean ch6 frame
        send_frame(5, 64'h6000, 20);
        wait_wr_en("t6_start", 20);
        tick();
        tick();
        expect_eq("t6_ovf_before", 64'(OVERFLOW), 64'h08);
        TX_ARESET = 1'b1;
        #1;
        expect_eq("t6_wr_en_cut", 64'(WR_EN), 64'd0);
        expect_eq("t6_ovf_cleared", 64'(OVERFLOW), 64'd0);
        expect_eq("t6_busy_cleared", 64'(BUSY), 64'd0);
        tick();
        tick();
        TX_ARESET = 1'b0;
        tick();
        mon_q.delete();
        send_frame(6, 64'h7000, 3);
        wait_words("t6_count", 3, 50);
        repeat (10) tick();
        expect_eq("t6_total", 64'(mon_q.size()), 64'd3);
        if (mon_q.size() >= 3) begin
            expect_eq("t6_ch", 64'(mon_q[0].ch), 64'd6);
            expect_eq("t6_data0", mon_q[0].data, 64'h7000);
            expect_eq("t6_data2", mon_q[2].data, 64'h7002);
            expect_eq("t6_last", 64'(mon_q[2].last), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
